// File: rtl/twiddle72_addr_seq.sv
// Twiddle ROM address sequencer for the 72-point mixed-radix FFT.
// Walks (n1, k2) row-major per frame and emits (n1*k2 + phase) mod 72,
// optionally conjugate-mapped for IFFT, plus ROM-valid tracking.
module twiddle72_addr_seq #(
  parameter int unsigned N1     = 8,
  parameter int unsigned N2     = 9,
  parameter int unsigned TW_LAT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        inv,
  input  logic [6:0]  phase,
  input  logic        adv,
  output logic [10:0] tw_addr,
  output logic        addr_valid,
  output logic [6:0]  n1_idx,
  output logic [6:0]  k2_idx,
  output logic        last,
  output logic        tw_valid,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] NPts   = 8'd72;
  localparam logic [6:0] N1Last = 7'(N1 - 1);
  localparam logic [6:0] N2Last = 7'(N2 - 1);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  logic       inv_q, inv_d;
  logic [6:0] ph_q, ph_d;
  logic [6:0] n1_q, n1_d;
  logic [6:0] k2_q, k2_d;
  logic [6:0] acc_q, acc_d;
  logic [6:0] addr_q, addr_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  logic       tw_valid_q;

  logic       accept;
  logic       at_last;
  logic       last_acc;
  logic       start_acc;
  logic [6:0] phase_wrap;
  logic [7:0] acc_sum;
  logic [7:0] acc_inc;

  // Next-state: start capture, row/column walk, running modular accumulator.
  always_comb begin
    state_d  = state_q;
    inv_d    = inv_q;
    ph_d     = ph_q;
    n1_d     = n1_q;
    k2_d     = k2_q;
    acc_d    = acc_q;
    valid_d  = valid_q;

    accept    = valid_q & adv;
    at_last   = (n1_q == N1Last) && (k2_q == N2Last);
    last_acc  = accept & at_last;
    // A running frame only takes a new start on its final accept.
    start_acc = ((state_q == StIdle) & start) | ((state_q == StRun) & last_acc & start);
    done_d    = last_acc;

    phase_wrap = (phase >= 7'd72) ? (phase - 7'd72) : phase;
    // acc < 72 and n1 <= 35, so one conditional subtract keeps it in range.
    acc_sum    = {1'b0, acc_q} + {1'b0, n1_q};
    acc_inc    = (acc_sum >= NPts) ? (acc_sum - NPts) : acc_sum;

    if (start_acc) begin
      state_d = StRun;
      inv_d   = inv;
      ph_d    = phase_wrap;
      n1_d    = '0;
      k2_d    = '0;
      acc_d   = phase_wrap;
      valid_d = 1'b1;
    end else if (accept) begin
      if (at_last) begin
        state_d = StIdle;
        valid_d = 1'b0;
      end else if (k2_q == N2Last) begin
        k2_d  = '0;
        n1_d  = n1_q + 7'd1;
        acc_d = ph_q;
      end else begin
        k2_d  = k2_q + 7'd1;
        acc_d = acc_inc[6:0];
      end
    end

    // Registered address mapping tracks acc_d so it always matches n1/k2.
    if (inv_d && (acc_d != 7'd0)) begin
      addr_d = NPts[6:0] - acc_d;
    end else begin
      addr_d = acc_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      inv_q   <= 1'b0;
      ph_q    <= '0;
      n1_q    <= '0;
      k2_q    <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      ph_q    <= ph_d;
      n1_q    <= n1_d;
      k2_q    <= k2_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // One-cycle accept delay, used when the ROM has an output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_valid_q <= 1'b0;
    end else begin
      tw_valid_q <= accept;
    end
  end

  // Output drive.
  always_comb begin
    tw_addr    = {4'b0000, addr_q};
    addr_valid = valid_q;
    n1_idx     = n1_q;
    k2_idx     = k2_q;
    last       = valid_q & at_last;
    tw_valid   = (TW_LAT == 0) ? accept : tw_valid_q;
    busy       = (state_q == StRun);
    done       = done_q;
  end

endmodule

// File: tb/tb_twiddle72_addr_seq.sv
// Bench for twiddle72_addr_seq: two instances (TW_LAT 0 and 1) driven in
// parallel, checked every cycle against an index-based frame model.
module tb_twiddle72_addr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       inv;
  logic [6:0] phase;
  logic       adv;

  logic [10:0] tw_addr0, tw_addr1;
  logic        av0, av1, last0, last1, tv0, tv1, busy0, busy1, done0, done1;
  logic [6:0]  n10, n11, k20, k21;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  twiddle72_addr_seq #(.N1(8), .N2(9), .TW_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .inv(inv), .phase(phase), .adv(adv),
    .tw_addr(tw_addr0), .addr_valid(av0), .n1_idx(n10), .k2_idx(k20), .last(last0),
    .tw_valid(tv0), .busy(busy0), .done(done0)
  );

  twiddle72_addr_seq #(.N1(8), .N2(9), .TW_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .inv(inv), .phase(phase), .adv(adv),
    .tw_addr(tw_addr1), .addr_valid(av1), .n1_idx(n11), .k2_idx(k21), .last(last1),
    .tw_valid(tv1), .busy(busy1), .done(done1)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Frame model: a frame is a list of 72 addresses indexed 0..71.
  bit m_valid = 0;
  int m_idx   = 0;
  int m_ph    = 0;
  bit m_inv   = 0;
  bit m_done  = 0;
  bit m_acc_d = 0;

  int cap_row = -1;
  int got_row [9];
  int tv_cnt  = 0;

  function automatic int model_addr(input int idx, input int ph, input bit iv);
    int a;
    a = ((idx / 9) * (idx % 9) + ph) % 72;
    if (iv && a != 0) a = 72 - a;
    return a;
  endfunction

  task automatic check_dut(input string t, input int a, input int av, input int n1,
                           input int k2, input int la, input int tv, input int bz,
                           input int dn, input int tv_exp);
    chk({t, ".addr_valid"}, av, int'(m_valid));
    chk({t, ".busy"}, bz, int'(m_valid));
    chk({t, ".last"}, la, int'(m_valid && m_idx == 71));
    chk({t, ".done"}, dn, int'(m_done));
    chk({t, ".tw_valid"}, tv, tv_exp);
    if (m_valid) begin
      chk({t, ".tw_addr"}, a, model_addr(m_idx, m_ph, m_inv));
      chk({t, ".n1_idx"}, n1, m_idx / 9);
      chk({t, ".k2_idx"}, k2, m_idx % 9);
    end else if (!rst_n) begin
      chk({t, ".tw_addr_rst"}, a, 0);
      chk({t, ".n1_idx_rst"}, n1, 0);
      chk({t, ".k2_idx_rst"}, k2, 0);
    end
  endtask

  // Compare on the falling edge, then advance the model to the next rising edge.
  always @(negedge clk) begin
    bit accept, last_acc, start_acc;
    if (!rst_n) begin
      m_valid = 0; m_idx = 0; m_done = 0; m_acc_d = 0;
    end
    check_dut("lat0", tw_addr0, av0, n10, k20, last0, tv0, busy0, done0,
              int'(m_valid && adv));
    check_dut("lat1", tw_addr1, av1, n11, k21, last1, tv1, busy1, done1, int'(m_acc_d));
    if (tv1) tv_cnt++;
    if (m_valid && cap_row >= 0 && m_idx / 9 == cap_row) got_row[m_idx % 9] = tw_addr0;
    if (rst_n) begin
      accept    = m_valid && adv;
      last_acc  = accept && m_idx == 71;
      start_acc = start && (!m_valid || last_acc);
      m_done    = last_acc;
      m_acc_d   = accept;
      if (start_acc) begin
        m_valid = 1; m_idx = 0; m_inv = inv;
        m_ph    = (phase >= 72) ? int'(phase) - 72 : int'(phase);
      end else if (accept) begin
        if (m_idx == 71) m_valid = 0;
        else m_idx++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_row(input string nm, input int e [9]);
    for (int k = 0; k < 9; k++) chk($sformatf("%s[%0d]", nm, k), got_row[k], e[k]);
  endtask

  // Start a frame and run it to its done pulse, optionally with random stalls.
  task automatic run_frame(input int ph, input bit iv, input int row, input bit stall);
    int n;
    cap_row = row;
    for (int k = 0; k < 9; k++) got_row[k] = -1;
    phase = 7'(ph); inv = iv; start = 1'b1; adv = 1'b0;
    tick();
    start = 1'b0;
    chk("start_latency", int'(av0), 1);
    n = 0;
    while (!done0 && n < 400) begin
      adv = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    if (n >= 400) chk("frame_timeout", 0, 1);
    adv = 1'b0;
    tick();
    cap_row = -1;
  endtask

  task automatic wait_idx(input int target);
    int n = 0;
    adv = 1'b1;
    while (!(m_valid && m_idx == target) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("wait_idx_timeout", 0, 1);
  endtask

  initial begin
    int n;
    int row_a [9] = '{0, 7, 14, 21, 28, 35, 42, 49, 56};
    int row_b [9] = '{0, 65, 58, 51, 44, 37, 30, 23, 16};
    int row_c [9] = '{70, 71, 0, 1, 2, 3, 4, 5, 6};
    int row_d [9] = '{28, 28, 28, 28, 28, 28, 28, 28, 28};

    rst_n = 1'b0; start = 1'b0; inv = 1'b0; phase = '0; adv = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;

    // Idle: adv toggling without start must produce nothing.
    for (int i = 0; i < 10; i++) begin
      adv = 1'(i % 2);
      tick();
    end
    adv = 1'b0;

    run_frame(0, 1'b0, 7, 1'b0);
    check_row("row7_fwd", row_a);
    run_frame(0, 1'b1, 7, 1'b0);
    check_row("row7_inv", row_b);
    run_frame(70, 1'b0, 1, 1'b0);
    check_row("row1_ph70", row_c);
    run_frame(100, 1'b0, 0, 1'b0);
    check_row("row0_ph100", row_d);

    // Random stalls; TW_LAT=1 instance must report exactly 72 valids.
    tv_cnt = 0;
    run_frame(5, 1'b1, -1, 1'b1);
    chk("tw_valid_count", tv_cnt, 72);

    // Back-to-back start on the final accept, then an ignored mid-frame start.
    phase = '0; inv = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(71);
    phase = 7'd33; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_done", int'(done0), 1);
    chk("b2b_valid", int'(av0), 1);
    chk("b2b_addr", int'(tw_addr0), 33);
    wait_idx(20);
    phase = 7'd50; inv = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (!done0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("b2b_timeout", 0, 1);
    adv = 1'b0;
    tick();

    // Reset mid-frame at address index 30: outputs clear before any clock edge.
    phase = 7'd9; inv = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    wait_idx(30);
    adv = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(av0), 0);
    chk("async_rst_busy", int'(busy1), 0);
    chk("async_rst_addr", int'(tw_addr0), 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    run_frame(3, 1'b0, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/twiddle72_addr_seq.md
# twiddle72_addr_seq

Address sequencer for the 72-entry twiddle ROM used between the two stages of the 72-point mixed-radix FFT (72 = N1 × N2). For each frame it walks the inter-stage samples in row-major order (n1 outer, k2 inner) and emits ROM address (n1·k2 + phase) mod 72, with an optional conjugate mapping for IFFT. It sits between the stage-1 output buffer / twiddle multiplier and the ROM, and flags when the ROM output is valid for the accepted address.

## Interface
- N1, 8, outer (row) factor; N1·N2 must equal 72, N1 ≥ 2
- N2, 9, inner (column) factor; N2 ≥ 2
- TW_LAT, 0, ROM output latency in cycles (0 or 1); must match the ROM output-register setting

- clk  in  1  master clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  frame start request
- inv  in  1  1 = IFFT (conjugate twiddles); captured on accepted start
- phase  in  7  additive address offset; captured on accepted start
- adv  in  1  consumer accepts the current address this cycle
- tw_addr  out  11  ROM address; upper 4 bits always 0
- addr_valid  out  1  tw_addr holds a frame address
- n1_idx  out  7  row index of the current address
- k2_idx  out  7  column index of the current address
- last  out  1  current address is the final one of the frame (n1=N1-1, k2=N2-1)
- tw_valid  out  1  ROM output holds the twiddle for an accepted address
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the final address is accepted

## Operation
- States: IDLE, RUN.
- Accepted start: IDLE & start, or RUN & last & addr_valid & adv & start (back-to-back). In all other RUN cycles, start is ignored.
- On accepted start, register: inv_r = inv; ph_r = phase, or phase−72 if phase ≥ 72; n1 = 0, k2 = 0, acc = ph_r. Enter RUN with addr_valid = 1 on the next cycle.
- Accept = addr_valid & adv. When not accepting, hold every register (stall).
- On accept, if not last:
  - k2 = N2−1: k2 ← 0, n1 ← n1+1, acc ← ph_r.
  - Otherwise: k2 ← k2+1, acc ← acc + n1, minus 72 if the sum ≥ 72. A single subtraction suffices: acc < 72 and n1 ≤ 35, so the 8-bit sum is < 108.
- Address mapping is registered and must be consistent with n1/k2:
  - inv_r = 0: tw_addr = acc.
  - inv_r = 1: tw_addr = (acc == 0) ? 0 : 72 − acc.
- On accept at last, with no new start: addr_valid ← 0, busy ← 0, state ← IDLE, done = 1 for exactly one cycle.
  - If a back-to-back start is accepted in the same cycle, done still pulses and the new frame begins seamlessly.
- busy = state RUN. last is combinational from n1/k2 and gated by addr_valid.
- tw_valid:
  - TW_LAT = 0: addr_valid & adv (combinational).
  - TW_LAT = 1: accept registered by one cycle.

## Timing
- Reset (async assert, sync-safe release): state IDLE; tw_addr 0, addr_valid 0, n1_idx 0, k2_idx 0, last 0, tw_valid 0, busy 0, done 0; internal tw_valid pipe cleared.
- Start-to-first-address latency: 1 cycle.
- Throughput: one address per cycle while adv = 1. A frame is 72 accepts, so the minimum frame period is 72 cycles back-to-back.
- done is asserted in the cycle after the final accept.
- Reset mid-frame: abandons the frame immediately with no done pulse. The first start after release begins a fresh frame.
- inv and phase changes during RUN have no effect until the next accepted start.

## Test plan
- Reset then idle: all outputs 0; adv toggling with no start produces no addr_valid and no tw_valid.
- N1=8, N2=9, phase=0, inv=0, adv held 1:
  - addr_valid rises 1 cycle after start.
  - Row n1=7 gives 0,7,14,21,28,35,42,49,56.
  - last is high on the 72nd address; done pulses the next cycle.
- inv=1, phase=0: row n1=7 gives 0,65,58,51,44,37,30,23,16. phase=70, inv=0: row n1=1 gives 70,71,0,1,2,3,4,5,6 (wrap).
- phase=100 captured as 28: row n1=0 gives 28 for all nine entries.
- Random adv stalls: tw_addr, n1_idx and k2_idx hold while adv=0. With TW_LAT=1, tw_valid lags each accept by exactly 1 cycle. The total count of tw_valid per frame is 72.
- Start asserted together with the final accept: done pulses, addr_valid stays 1, next tw_addr = new phase.
- Start asserted mid-frame is ignored.
- rst_n pulsed at address 30: all outputs clear asynchronously and no done appears.
